// File: rtl/uart_mm_cmd_bridge.sv
// UART byte-stream command bridge: decodes read/write burst frames into
// memory accesses, streams read data back and answers writes with ACK/NAK.
module uart_mm_cmd_bridge #(
  parameter int NUM_BYTES_DATA    = 4,
  parameter int NUM_BYTES_ADDRESS = 1,
  parameter int TIMEOUT_CYCLES    = 1000000
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_data,
  output logic                           mem_we,
  output logic [NUM_BYTES_ADDRESS*8-1:0] mem_waddr,
  output logic [NUM_BYTES_DATA*8-1:0]    mem_wdata,
  output logic                           mem_re,
  output logic [NUM_BYTES_ADDRESS*8-1:0] mem_raddr,
  input  logic [NUM_BYTES_DATA*8-1:0]    mem_rdata,
  input  logic                           mem_rdy,
  output logic                           busy,
  output logic                           drop_pulse
);

  localparam int AW = NUM_BYTES_ADDRESS * 8;
  localparam int DW = NUM_BYTES_DATA * 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0]    ADDR_LAST = 3'(NUM_BYTES_ADDRESS - 1);
  localparam logic [2:0]    DATA_LAST = 3'(NUM_BYTES_DATA - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    ACK       = 8'hA5;
  localparam logic [7:0]    NAK       = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RD_REQ,
    RD_SEND,
    RESP
  } state_t;

  state_t        state;
  logic          is_read;
  logic [6:0]    words_left;
  logic [2:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [AW-1:0] addr;
  logic [DW-1:0] word;

  logic [AW-1:0] addr_shift;
  logic [AW-1:0] addr_inc;
  logic [DW-1:0] word_shift;
  logic [DW-1:0] word_next_tx;

  assign addr_shift   = AW'({addr, rx_data});
  assign addr_inc     = addr + AW'(1);
  assign word_shift   = DW'({word, rx_data});
  assign word_next_tx = word << 8;

  assign busy       = (state != IDLE);
  // Bytes arriving while the bridge is not collecting a frame are discarded in the same cycle.
  assign drop_pulse = rx_valid && (state inside {WRITE, RD_REQ, RD_SEND, RESP});

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      is_read    <= 1'b0;
      words_left <= '0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      addr       <= '0;
      word       <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_re     <= 1'b0;
      mem_raddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            is_read    <= rx_data[7];
            words_left <= rx_data[6:0];
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            state      <= ADDR;
          end
        end

        ADDR: begin
          // An accepted byte takes priority over a timeout reached in the same cycle.
          if (rx_valid) begin
            addr    <= addr_shift;
            tmo_cnt <= '0;
            if (byte_cnt == ADDR_LAST) begin
              byte_cnt <= '0;
              if (is_read) begin
                mem_re    <= 1'b1;
                mem_raddr <= addr_shift;
                state     <= RD_REQ;
              end else begin
                state <= WDATA;
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (tmo_cnt >= TMO_LIMIT) begin
            tx_valid <= 1'b1;
            tx_data  <= NAK;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        WDATA: begin
          if (rx_valid) begin
            word    <= word_shift;
            tmo_cnt <= '0;
            if (byte_cnt == DATA_LAST) begin
              byte_cnt  <= '0;
              mem_we    <= 1'b1;
              mem_waddr <= addr;
              mem_wdata <= word_shift;
              state     <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (tmo_cnt >= TMO_LIMIT) begin
            tx_valid <= 1'b1;
            tx_data  <= NAK;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        WRITE: begin
          mem_we <= 1'b0;
          addr   <= addr_inc;
          if (words_left == 7'd0) begin
            tx_valid <= 1'b1;
            tx_data  <= ACK;
            state    <= RESP;
          end else begin
            words_left <= words_left - 7'd1;
            state      <= WDATA;
          end
        end

        RD_REQ: begin
          if (mem_rdy) begin
            mem_re   <= 1'b0;
            word     <= mem_rdata;
            tx_valid <= 1'b1;
            tx_data  <= mem_rdata[DW-1 -: 8];
            byte_cnt <= '0;
            state    <= RD_SEND;
          end
        end

        RD_SEND: begin
          // The captured word is shifted left so the next byte to send is always at the top.
          if (tx_ready) begin
            if (byte_cnt == DATA_LAST) begin
              byte_cnt <= '0;
              tx_valid <= 1'b0;
              addr     <= addr_inc;
              if (words_left == 7'd0) begin
                state <= IDLE;
              end else begin
                words_left <= words_left - 7'd1;
                mem_re     <= 1'b1;
                mem_raddr  <= addr_inc;
                state      <= RD_REQ;
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              word     <= word_next_tx;
              tx_data  <= word_next_tx[DW-1 -: 8];
            end
          end
        end

        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mm_cmd_bridge.sv
// Scoreboard bench for uart_mm_cmd_bridge: directed frames for the listed
// scenarios followed by randomized read/write bursts against a memory model.
module tb_uart_mm_cmd_bridge;

  localparam int NBD = 4;
  localparam int NBA = 1;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;
  logic        busy;
  logic        drop_pulse;

  always #5 clk = ~clk;

  uart_mm_cmd_bridge #(
    .NUM_BYTES_DATA   (NBD),
    .NUM_BYTES_ADDRESS(NBA),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .busy      (busy),
    .drop_pulse(drop_pulse)
  );

  int checks = 0;
  int errors = 0;
  int tx_mode = 0;      // 0: ready always high, 1: random, 2: driven by main sequence
  int rdy_delay = 0;
  int gap_max = 0;
  int drops_exp = 0;
  int drops_seen = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] model_mem [256];
  logic [31:0] wdat [128];
  wr_t         exp_wr[$];
  logic [7:0]  exp_raddr[$];
  logic [7:0]  exp_tx[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Scoreboard monitor: compares every DUT-presented event against the queues.
  initial begin : monitor
    wr_t        e;
    logic [7:0] held;
    logic       prev_re;
    logic       prev_we;
    prev_re = 1'b0;
    prev_we = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (mem_we || mem_re) check("we_re_exclusive", 64'(mem_we && mem_re), 0);
      if (mem_we) begin
        check("we_single_cycle", 64'(prev_we), 0);
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write", $sformatf("got write addr %0h data %0h, none expected", mem_waddr, mem_wdata));
        end else begin
          e = exp_wr.pop_front();
          check("write_addr", 64'(mem_waddr), 64'(e.a));
          check("write_data", 64'(mem_wdata), 64'(e.d));
        end
      end
      if (mem_re && !prev_re) begin
        held = mem_raddr;
        if (exp_raddr.size() == 0)
          fail_now("unexpected_read", $sformatf("got read addr %0h, none expected", mem_raddr));
        else
          check("read_addr", 64'(mem_raddr), 64'(exp_raddr.pop_front()));
      end else if (mem_re) begin
        check("raddr_stable", 64'(mem_raddr), 64'(held));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0)
          fail_now("unexpected_tx", $sformatf("got tx byte %0h, none expected", tx_data));
        else
          check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
      if (drop_pulse) drops_seen++;
      prev_re = mem_re;
      prev_we = mem_we;
    end
  end

  initial begin : tx_ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (tx_mode == 0) tx_ready = 1'b1;
      else if (tx_mode == 1) tx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : mem_responder
    forever begin
      @(posedge clk);
      #1;
      if (mem_re) begin
        repeat (rdy_delay) begin
          @(posedge clk);
          #1;
        end
        mem_rdata = model_mem[mem_raddr];
        mem_rdy   = 1'b1;
        @(posedge clk);
        #1;
        mem_rdy   = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rgap();
    return (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
  endfunction

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (busy) fail_now(name, "bridge still busy after 3000 cycles");
  endtask

  task automatic wait_tx_valid(input string name);
    int k;
    k = 0;
    while (!tx_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!tx_valid) fail_now(name, "tx_valid never asserted within 200 cycles");
  endtask

  task automatic push_write(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    model_mem[a] = d;
    exp_wr.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[31-8*b -: 8]);
      if (gaps && b < 3) idle(rgap());
    end
  endtask

  task automatic do_write(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) push_write(8'(a + 8'(i)), wdat[i]);
    exp_tx.push_back(8'hA5);
    send_byte({1'b0, 7'(n - 1)});
    idle(rgap());
    send_byte(a);
    idle(rgap());
    for (int i = 0; i < n; i++) begin
      send_word(wdat[i], 1'b1);
      if (i < n - 1) idle(1 + rgap());
    end
    wait_idle("write_done");
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    logic [7:0]  ad;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      ad = 8'(a + 8'(i));
      w  = model_mem[ad];
      exp_raddr.push_back(ad);
      for (int b = 0; b < 4; b++) exp_tx.push_back(w[31-8*b -: 8]);
    end
    send_byte({1'b1, 7'(n - 1)});
    idle(rgap());
    send_byte(a);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_valid"}, 64'(tx_valid), 0);
    check({tag, "_tx_data"}, 64'(tx_data), 0);
    check({tag, "_mem_we"}, 64'(mem_we), 0);
    check({tag, "_mem_waddr"}, 64'(mem_waddr), 0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
    check({tag, "_mem_re"}, 64'(mem_re), 0);
    check({tag, "_mem_raddr"}, 64'(mem_raddr), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_drop_pulse"}, 64'(drop_pulse), 0);
  endtask

  initial begin : main
    logic [31:0] w;
    int          n;
    logic [7:0]  a;

    for (int i = 0; i < 256; i++) model_mem[i] = $urandom;

    // Reset state
    @(negedge clk);
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    idle(2);

    // Single-word write
    wdat[0] = 32'hDEADBEEF;
    do_write(8'h10, 1);

    // Two-word read wrapping the address, slow mem_rdy, tx stall mid-word
    model_mem[8'hFF] = 32'h11223344;
    model_mem[8'h00] = 32'h55667788;
    rdy_delay = 3;
    tx_mode   = 2;
    tx_ready  = 1'b0;
    do_read(8'hFF, 2);
    wait_tx_valid("read_first_tx");
    tx_ready = 1'b1;
    idle(2);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_tx_data", 64'(tx_data), 64'h33);
      check("stall_tx_valid", 64'(tx_valid), 1);
      @(posedge clk);
      #1;
    end
    tx_mode  = 0;
    tx_ready = 1'b1;
    wait_idle("read_burst_done");
    rdy_delay = 0;

    // Timeout in the second word: first word written, then NAK
    w = 32'hCAFE0123;
    push_write(8'h20, w);
    exp_tx.push_back(8'h5A);
    send_byte(8'h01);
    send_byte(8'h20);
    send_word(w, 1'b0);
    idle(1);
    send_byte(8'h99);
    send_byte(8'h77);
    wait_idle("timeout_done");

    // Byte received during RD_SEND is dropped, read data unaffected
    rdy_delay = 1;
    tx_mode   = 2;
    tx_ready  = 1'b0;
    do_read(8'h50, 1);
    wait_tx_valid("drop_first_tx");
    rx_data  = 8'hC3;
    rx_valid = 1'b1;
    drops_exp++;
    @(negedge clk);
    check("drop_pulse_high", 64'(drop_pulse), 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("drop_pulse_low", 64'(drop_pulse), 0);
    @(posedge clk);
    #1;
    tx_mode  = 0;
    tx_ready = 1'b1;
    wait_idle("drop_read_done");
    rdy_delay = 0;

    // Reset mid-WDATA abandons the frame silently
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'hAA);
    send_byte(8'hBB);
    arst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    idle(2);
    arst_n = 1'b1;
    idle(4);
    wdat[0] = 32'h0BADF00D;
    do_write(8'h30, 1);

    // Byte arriving on the exact timeout cycle is accepted (data and address phases)
    w = 32'h13579BDF;
    push_write(8'h40, w);
    exp_tx.push_back(8'hA5);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(w[31:24]);
    idle(TMO);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    wait_idle("boundary_data_done");

    w = 32'h2468ACE0;
    push_write(8'h41, w);
    exp_tx.push_back(8'hA5);
    send_byte(8'h00);
    idle(TMO);
    send_byte(8'h41);
    send_word(w, 1'b0);
    wait_idle("boundary_addr_done");

    // Read command abandoned in the address phase: NAK, no read
    exp_tx.push_back(8'h5A);
    send_byte(8'h80);
    wait_idle("addr_timeout_done");

    // Randomized bursts
    tx_mode = 1;
    gap_max = 3;
    for (int f = 0; f < 40; f++) begin
      rdy_delay = int'($urandom_range(0, 4));
      n = int'($urandom_range(1, 4));
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wdat[i] = $urandom;
        do_write(a, n);
      end else begin
        do_read(a, n);
        wait_idle("random_read_done");
      end
    end
    tx_mode = 0;
    idle(5);

    check("pending_writes", 64'(exp_wr.size()), 0);
    check("pending_reads", 64'(exp_raddr.size()), 0);
    check("pending_tx", 64'(exp_tx.size()), 0);
    check("drop_count", 64'(drops_seen), 64'(drops_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
